// File: rtl/homomorphic_pkg.sv
// homomorphic_pkg: shared state encoding, default widths/moduli and element slicing helper
package homomorphic_pkg;
    localparam int PLAINTEXT_MODULUS  = 64;
    localparam int PLAINTEXT_WIDTH    = 6;
    localparam int DIMENSION          = 1;
    localparam int CIPHERTEXT_MODULUS = 1024;
    localparam int CIPHERTEXT_WIDTH   = 10;
    localparam int BIG_N              = 30;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    function automatic int elem_offset(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/homomorphic_add_ctrl_mod_add.sv
// mod_add: combinational single-element modular adder with operand range flag
module mod_add #(
    parameter int Q = 1024,
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         out_of_range
);
    localparam logic [W:0] QV = (W+1)'(Q);
    logic [W:0] s;
    always_comb begin
        s            = {1'b0, a} + {1'b0, b};
        sum          = W'(s >= QV ? s - QV : s);
        out_of_range = ({1'b0, a} >= QV) || ({1'b0, b} >= QV);
    end
endmodule

// File: rtl/homomorphic_add_ctrl.sv
// homomorphic_add_ctrl: time-shares one modular adder across the elements of two ciphertext vectors
module homomorphic_add_ctrl
    import homomorphic_pkg::*;
#(
    parameter int DIMENSION          = homomorphic_pkg::DIMENSION,
    parameter int CIPHERTEXT_MODULUS = homomorphic_pkg::CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = homomorphic_pkg::CIPHERTEXT_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0] ciphertext1,
    input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0] ciphertext2,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0] result,
    output logic                                     busy,
    output logic                                     err
);
    localparam int W  = CIPHERTEXT_WIDTH;
    localparam int N  = DIMENSION + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIMENSION);

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic [N*W-1:0] a_q, b_q, res_q;
    logic [W-1:0]  a_e, b_e, sum;
    logic          oor;

    assign a_e    = a_q[elem_offset(int'(idx), W) +: W];
    assign b_e    = b_q[elem_offset(int'(idx), W) +: W];
    assign result = res_q;

    mod_add #(.Q(CIPHERTEXT_MODULUS), .W(W)) u_add (
        .a(a_e), .b(b_e), .sum(sum), .out_of_range(oor)
    );

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        state_nx  = (state == IDLE && in_valid)     ? ADD  :
                    (state == ADD  && idx == LAST)  ? DONE :
                    (state == DONE && out_ready)    ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q <= ciphertext1;
                b_q <= ciphertext2;
                idx <= '0;
            end
            if (state == ADD) begin
                // out-of-range operands yield a zero element but do not stall the sweep
                res_q[elem_offset(int'(idx), W) +: W] <= oor ? '0 : sum;
                idx <= (idx == LAST) ? '0 : idx + IW'(1);
                if (oor) err <= 1'b1;
            end
        end
    end
endmodule
